// File: rtl/mel_window_reader.sv
// Streams a consistent snapshot of the mel shift window (oldest frame first) over valid/ready,
// compensating for window shifts mid-read. Optional build macro MEL_READER_CLAMP_EN enables ReLU on data.
module mel_window_reader #(
  parameter int NUM_FRAMES = 256,
  parameter int NUM_COEFF  = 40,
  parameter int BIT_WIDTH  = 16,
  localparam int FW = $clog2(NUM_FRAMES),
  localparam int CW = $clog2(NUM_COEFF),
  localparam int SW = FW + 1
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 start,
  input  logic                                                 mel_valid,
  input  logic [0:NUM_FRAMES-1][0:NUM_COEFF-1][BIT_WIDTH-1:0] window,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [BIT_WIDTH-1:0]                                 out_data,
  output logic [FW-1:0]                                        out_frame,
  output logic [CW-1:0]                                        out_coeff,
  output logic                                                 out_last,
  output logic                                                 busy,
  output logic                                                 done,
  output logic                                                 overrun
);

  typedef enum logic [2:0] {IDLE, FETCH, STREAM, DONE, ERR} state_t;

  state_t               state, state_nxt;
  logic [FW-1:0]        frame_idx;
  logic [CW-1:0]        coeff_idx;
  logic [SW-1:0]        shift_cnt;
  logic [FW-1:0]        phys_idx;
  logic [BIT_WIDTH-1:0] fetch_word;
  logic                 accept;
  logic                 overrun_hit;
  logic                 do_fetch;
  logic                 do_err;
  logic                 clear;

  function automatic logic [BIT_WIDTH-1:0] clamp_word(input logic signed [BIT_WIDTH-1:0] w);
`ifdef MEL_READER_CLAMP_EN
    return (w < 0) ? '0 : w;
`else
    return w;
`endif
  endfunction

  assign busy        = (state == FETCH) || (state == STREAM);
  assign accept      = out_valid && out_ready;
  // Logical frame f now lives at physical f-s; s>f means it already fell off the window.
  assign overrun_hit = shift_cnt > {1'b0, frame_idx};
  assign phys_idx    = frame_idx - shift_cnt[FW-1:0];
  assign fetch_word  = window[phys_idx][coeff_idx];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_fetch  = 1'b0;
    do_err    = 1'b0;
    clear     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
          clear     = 1'b1;
        end
      end
      FETCH: begin
        if (overrun_hit) begin
          state_nxt = ERR;
          do_err    = 1'b1;
        end else begin
          state_nxt = STREAM;
          do_fetch  = 1'b1;
        end
      end
      STREAM: begin
        if (accept) begin
          if (out_last) begin
            state_nxt = DONE;
          end else if (overrun_hit) begin
            state_nxt = ERR;
            do_err    = 1'b1;
          end else begin
            do_fetch  = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters and output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_idx <= '0;
      coeff_idx <= '0;
      shift_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_frame <= '0;
      out_coeff <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (clear) begin
        frame_idx <= '0;
        coeff_idx <= '0;
        shift_cnt <= '0;
        overrun   <= 1'b0;
      end else begin
        if (busy && mel_valid && (shift_cnt != SW'(NUM_FRAMES)))
          shift_cnt <= shift_cnt + SW'(1);
        if (do_fetch) begin
          if (coeff_idx == CW'(NUM_COEFF - 1)) begin
            coeff_idx <= '0;
            frame_idx <= frame_idx + FW'(1);
          end else begin
            coeff_idx <= coeff_idx + CW'(1);
          end
        end
        if (do_err) overrun <= 1'b1;
      end

      // The fetch sees the pre-shift window, so it uses the current s even if mel_valid is high.
      if (do_fetch) begin
        out_valid <= 1'b1;
        out_data  <= clamp_word(fetch_word);
        out_frame <= frame_idx;
        out_coeff <= coeff_idx;
        out_last  <= (frame_idx == FW'(NUM_FRAMES - 1)) && (coeff_idx == CW'(NUM_COEFF - 1));
      end else if (accept) begin
        out_valid <= 1'b0;
      end

      done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_mel_window_reader.sv
// Directed bench for mel_window_reader: full reads, backpressure, shift tracking, overrun,
// start/reset during a read and the optional clamp build.
module tb_mel_window_reader;

  localparam int NF    = 256;
  localparam int NC    = 40;
  localparam int TOTAL = NF * NC;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        start;
  logic                        mel_valid;
  logic [0:NF-1][0:NC-1][15:0] window;
  logic                        out_valid;
  logic                        out_ready;
  logic [15:0]                 out_data;
  logic [7:0]                  out_frame;
  logic [5:0]                  out_coeff;
  logic                        out_last;
  logic                        busy;
  logic                        done;
  logic                        overrun;

  int tests = 0;
  int fails = 0;
  int base  = 0;

  mel_window_reader #(.NUM_FRAMES(NF), .NUM_COEFF(NC), .BIT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .mel_valid(mel_valid), .window(window),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_frame(out_frame), .out_coeff(out_coeff), .out_last(out_last),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Physical slot p holds original frame p+base; the word is {frame[7:0], coeff[7:0]}.
  task automatic build_window();
    for (int p = 0; p < NF; p++)
      for (int c = 0; c < NC; c++)
        window[p][c] = {8'(p + base), 8'(c)};
  endtask

  task automatic apply_reset();
    @(posedge clk) #1;
    reset = 1'b1; start = 1'b0; mel_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Runs one read and reports observations; the calling test does the comparisons.
  task automatic stream_read(input bit toggle, input int shift_at,
                             output int bad, output int first_bad, output int stall_bad,
                             output int gaps, output int beats, output int first_n,
                             output int last_n, output int done_n, output int done_w,
                             output bit ovr);
    int          shifts_left;
    bit          shifted;
    bit          pstall;
    logic [15:0] pd;
    logic [7:0]  pf;
    logic [5:0]  pc;
    logic        pl;
    logic [15:0] exp_d;
    bad = 0; first_bad = -1; stall_bad = 0; gaps = 0; beats = 0; first_n = -1;
    last_n = -1; done_n = -1; done_w = 0; ovr = 1'b0;
    shifts_left = 0; shifted = 1'b0; pstall = 1'b0; pd = '0; pf = '0; pc = '0; pl = 1'b0;
    base = 0; build_window();
    @(posedge clk) #1;
    start = 1'b1; out_ready = 1'b1; mel_valid = 1'b0;
    @(posedge clk) #1;
    start = 1'b0;
    for (int n = 0; n < 30000; n++) begin
      @(negedge clk);
      if (overrun) ovr = 1'b1;
      if (out_valid && first_n < 0) first_n = n;
      if (pstall && (!out_valid || out_data !== pd || out_frame !== pf ||
                     out_coeff !== pc || out_last !== pl)) stall_bad++;
      if (!out_valid && beats > 0 && beats < TOTAL) gaps++;
      if (done) begin
        if (done_n < 0) done_n = n;
        done_w++;
      end
      if (out_valid && out_ready) begin
        exp_d = {8'(beats / NC), 8'(beats % NC)};
        if (out_data !== exp_d || out_frame !== 8'(beats / NC) ||
            out_coeff !== 6'(beats % NC) || out_last !== (beats == TOTAL - 1)) begin
          if (first_bad < 0) first_bad = beats;
          bad++;
        end
        if (beats == TOTAL - 1) last_n = n;
        beats++;
      end
      pstall = out_valid && !out_ready;
      pd = out_data; pf = out_frame; pc = out_coeff; pl = out_last;
      @(posedge clk) #1;
      if (mel_valid) begin
        base++;
        build_window();
      end
      mel_valid = 1'b0;
      if (shift_at >= 0 && beats == shift_at && !shifted) begin
        shifts_left = 3;
        shifted = 1'b1;
      end
      if (shifts_left > 0) begin
        mel_valid = 1'b1;
        shifts_left--;
      end
      if (toggle) out_ready = ~out_ready;
      if (done_n >= 0 && n >= done_n + 2) break;
    end
    out_ready = 1'b1;
    mel_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; mel_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({out_valid, out_last, busy, done, overrun} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b required 00000", {out_valid, out_last, busy, done, overrun});
    end
    tests++;
    if ({out_data, out_frame, out_coeff} !== 30'h0) begin
      fails++; $display("FAIL reset_data: got %h/%h/%h required 0/0/0", out_data, out_frame, out_coeff);
    end
    #1 start = 1'b0;
    @(posedge clk) #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_stream();
    int bad, fb, sb, gaps, beats, fn, ln, dn, dw;
    bit ovr;
    stream_read(1'b0, -1, bad, fb, sb, gaps, beats, fn, ln, dn, dw, ovr);
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL stream_seq: %0d bad beats (first %0d) required 0", bad, fb); end
    tests++;
    if (beats !== TOTAL) begin fails++; $display("FAIL stream_beats: got %0d required %0d", beats, TOTAL); end
    tests++;
    if (gaps !== 0) begin fails++; $display("FAIL stream_gaps: got %0d required 0", gaps); end
    tests++;
    if (fn !== 1) begin fails++; $display("FAIL stream_first_latency: got %0d required 1", fn); end
    tests++;
    if (dn - ln !== 2) begin fails++; $display("FAIL stream_done_after_last: got %0d required 2", dn - ln); end
    tests++;
    if (dn !== TOTAL + 2) begin fails++; $display("FAIL stream_done_cycle: got %0d required %0d", dn, TOTAL + 2); end
    tests++;
    if (dw !== 1) begin fails++; $display("FAIL stream_done_width: got %0d required 1", dw); end
    tests++;
    if (ovr !== 1'b0) begin fails++; $display("FAIL stream_overrun: got %b required 0", ovr); end
  endtask

  task automatic test_backpressure();
    int bad, fb, sb, gaps, beats, fn, ln, dn, dw;
    bit ovr;
    stream_read(1'b1, -1, bad, fb, sb, gaps, beats, fn, ln, dn, dw, ovr);
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL bp_seq: %0d bad beats (first %0d) required 0", bad, fb); end
    tests++;
    if (beats !== TOTAL) begin fails++; $display("FAIL bp_beats: got %0d required %0d", beats, TOTAL); end
    tests++;
    if (sb !== 0) begin fails++; $display("FAIL bp_stall_stable: got %0d unstable stalls required 0", sb); end
    tests++;
    if (gaps !== 0) begin fails++; $display("FAIL bp_gaps: got %0d required 0", gaps); end
    tests++;
    if (dn - ln !== 2 || dw !== 1) begin
      fails++; $display("FAIL bp_done: got offset %0d width %0d required 2 and 1", dn - ln, dw);
    end
  endtask

  task automatic test_shift_tracking();
    int bad, fb, sb, gaps, beats, fn, ln, dn, dw;
    bit ovr;
    stream_read(1'b0, 200, bad, fb, sb, gaps, beats, fn, ln, dn, dw, ovr);
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL shift_snapshot: %0d bad beats (first %0d) required 0", bad, fb); end
    tests++;
    if (base !== 3) begin fails++; $display("FAIL shift_count_applied: got %0d required 3", base); end
    tests++;
    if (beats !== TOTAL || dw !== 1) begin
      fails++; $display("FAIL shift_complete: got beats %0d done %0d required %0d and 1", beats, dw, TOTAL);
    end
    tests++;
    if (ovr !== 1'b0) begin fails++; $display("FAIL shift_overrun: got %b required 0", ovr); end
  endtask

  task automatic test_overrun();
    int hit_n;
    int done_seen;
    hit_n = -1; done_seen = 0;
    base = 0; build_window();
    @(posedge clk) #1;
    start = 1'b1; mel_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk) #1;
    start = 1'b0; base++; build_window();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (overrun) begin hit_n = n; break; end
      @(posedge clk) #1;
      base++; build_window();
    end
    tests++;
    if (hit_n !== 2) begin fails++; $display("FAIL ovr_detect_cycle: got %0d required 2", hit_n); end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL ovr_valid_drop: got %b required 0", out_valid); end
    @(posedge clk) #1 mel_valid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    tests++;
    if (done_seen !== 0) begin fails++; $display("FAIL ovr_no_done: got %0d pulses required 0", done_seen); end
    tests++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL ovr_sticky: got overrun %b busy %b required 1 and 0", overrun, busy);
    end
    base = 0; build_window();
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    @(negedge clk);
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear_on_start: got %b required 0", overrun); end
    apply_reset();
  endtask

  task automatic test_start_ignored_and_reset();
    int  beats, bad;
    bit  restarted;
    logic [15:0] exp_d;
    beats = 0; bad = 0; restarted = 1'b0;
    base = 0; build_window();
    @(posedge clk) #1;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        exp_d = {8'(beats / NC), 8'(beats % NC)};
        if (out_data !== exp_d) bad++;
        beats++;
      end
      @(posedge clk) #1;
      start = 1'b0;
      if (beats == 50 && !restarted) begin start = 1'b1; restarted = 1'b1; end
      if (beats == 100) break;
    end
    tests++;
    if (bad !== 0 || beats !== 100) begin
      fails++; $display("FAIL restart_ignored: got %0d bad of %0d beats required 0 of 100", bad, beats);
    end
    reset = 1'b1;
    @(posedge clk) #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid, out_data, out_frame, out_coeff, out_last, busy, done, overrun} !== 35'h0) begin
      fails++; $display("FAIL midread_reset: got valid %b data %h frame %h coeff %h busy %b required all 0",
                        out_valid, out_data, out_frame, out_coeff, busy);
    end
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({out_valid, out_data, out_frame, out_coeff} !== {1'b1, 16'h0000, 8'h00, 6'h00}) begin
      fails++; $display("FAIL fresh_first_beat: got valid %b data %h frame %h coeff %h required 1 0000 00 00",
                        out_valid, out_data, out_frame, out_coeff);
    end
    @(negedge clk);
    tests++;
    if ({out_data, out_coeff} !== {16'h0001, 6'h01}) begin
      fails++; $display("FAIL fresh_second_beat: got data %h coeff %h required 0001 01", out_data, out_coeff);
    end
    apply_reset();
  endtask

  task automatic test_clamp();
    logic [15:0] exp00;
`ifdef MEL_READER_CLAMP_EN
    exp00 = 16'h0000;
`else
    exp00 = 16'h8001;
`endif
    base = 0; build_window();
    window[0][0] = 16'h8001;
    window[0][1] = 16'h7FFF;
    @(posedge clk) #1 start = 1'b1; out_ready = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (out_data !== exp00) begin fails++; $display("FAIL clamp_negative: got %h required %h", out_data, exp00); end
    @(negedge clk);
    tests++;
    if (out_data !== 16'h7FFF) begin fails++; $display("FAIL clamp_positive: got %h required 7fff", out_data); end
    apply_reset();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mel_valid = 1'b0; out_ready = 1'b1;
    base = 0; build_window();
    test_reset();
    test_stream();
    test_backpressure();
    test_shift_tracking();
    test_overrun();
    test_start_ignored_and_reset();
    test_clamp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
